// File: rtl/pipo_arb_pkg.sv
// Shared types and helpers for the PIPO load arbiter.
// Optional build macro used by this slice: PIPO_PARITY_EN (adds q_par).
package pipo_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StDone
    } state_e;

    // Index width for NREQ requesters; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam bit QRstBit = 1'b0;

endpackage

// File: rtl/pipo_load_arbiter_if.sv
// Requester-side bus of the PIPO load arbiter.
// PIPO_PARITY_EN defined adds the registered parity bit q_par.
interface pipo_load_arbiter_if
    import pipo_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
) ();

    localparam int unsigned PtrW = ptr_w(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wr_data;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic [PtrW-1:0]       owner;
    logic                  busy;
`ifdef PIPO_PARITY_EN
    logic                  q_par;

    modport master (output req, wr_data, input grant, ack, q, owner, busy, q_par);
    modport slave  (input req, wr_data, output grant, ack, q, owner, busy, q_par);
`else
    modport master (output req, wr_data, input grant, ack, q, owner, busy);
    modport slave  (input req, wr_data, output grant, ack, q, owner, busy);
`endif

endinterface

// File: rtl/pipo_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after rr_ptr_i,
// wrapping modulo NREQ.
module pipo_rr_pick
    import pipo_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned PtrW = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PtrW-1:0] rr_ptr_i,
    output logic            valid_o,
    output logic [PtrW-1:0] sel_o
);

    int unsigned idx;

    // Scan from the farthest offset back to the pointer so the nearest hit wins.
    always_comb begin
        valid_o = 1'b0;
        sel_o   = '0;
        idx     = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (32'(rr_ptr_i) + 32'(i)) % NREQ;
            if (req_i[idx[PtrW-1:0]]) begin
                valid_o = 1'b1;
                sel_o   = idx[PtrW-1:0];
            end
        end
    end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter and load sequencer sharing one PIPO register among NREQ requesters.
// PIPO_PARITY_EN defined adds q_par = ^q, registered alongside q.
module pipo_load_arbiter
    import pipo_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
) (
    input logic               clk,
    input logic               rst_n,
    pipo_load_arbiter_if.slave bus
);

    localparam int unsigned PtrW = ptr_w(NREQ);

    state_e           state_q, state_d;
    logic [PtrW-1:0]  sel_q, sel_d;
    logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]  owner_q, owner_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             pick_valid;
    logic [PtrW-1:0]  pick_sel;
    logic [NREQ-1:0]  sel_onehot;

    pipo_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (pick_valid),
        .sel_o    (pick_sel)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        q_d        = q_q;
        sel_onehot = {{(NREQ - 1){1'b0}}, 1'b1} << sel_q;
        bus.grant  = '0;
        bus.ack    = '0;
        bus.busy   = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    sel_d   = pick_sel;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                bus.grant = sel_onehot;
                // A request withdrawn during GRANT aborts without loading or rotating.
                if (bus.req[sel_q]) begin
                    q_d     = bus.wr_data[32'(sel_q) * WIDTH +: WIDTH];
                    owner_d = sel_q;
                    state_d = StDone;
                end else begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                bus.ack  = sel_onehot;
                rr_ptr_d = (sel_q == PtrW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef PIPO_PARITY_EN
    logic q_par_q;
    assign bus.q_par = q_par_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            q_q      <= {WIDTH{QRstBit}};
`ifdef PIPO_PARITY_EN
            q_par_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            q_q      <= q_d;
`ifdef PIPO_PARITY_EN
            q_par_q  <= ^q_d;
`endif
        end
    end

    assign bus.q     = q_q;
    assign bus.owner = owner_q;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Self-checking bench for pipo_load_arbiter: directed scenarios plus random requesters,
// all outputs compared every cycle against a transaction-level model.
module tb_pipo_load_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREQ  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pipo_load_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    pipo_load_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model: phase 0 = waiting, 1 = owner granted, 2 = load acknowledged.
    int         m_phase = 0;
    int         m_ptr   = 0;
    int         m_sel   = 0;
    int         m_owner = 0;
    logic [7:0] m_q     = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_ptr   = 0;
            m_sel   = 0;
            m_owner = 0;
            m_q     = 8'h00;
        end else begin
            case (m_phase)
                0: begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (m_phase == 0 && bus.req[(m_ptr + k) % NREQ]) begin
                            m_sel   = (m_ptr + k) % NREQ;
                            m_phase = 1;
                        end
                    end
                end
                1: begin
                    if (bus.req[m_sel]) begin
                        m_q     = bus.wr_data[m_sel*WIDTH +: WIDTH];
                        m_owner = m_sel;
                        m_phase = 2;
                    end else begin
                        m_phase = 0;
                    end
                end
                default: begin
                    m_ptr   = (m_sel + 1) % NREQ;
                    m_phase = 0;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] one;
        one = 4'b0001 << m_sel;
        check("cyc_grant", 32'(bus.grant), (m_phase == 1) ? 32'(one) : 32'd0);
        check("cyc_ack",   32'(bus.ack),   (m_phase == 2) ? 32'(one) : 32'd0);
        check("cyc_busy",  32'(bus.busy),  (m_phase != 0) ? 32'd1 : 32'd0);
        check("cyc_q",     32'(bus.q),     32'(m_q));
        check("cyc_owner", 32'(bus.owner), 32'(m_owner));
`ifdef PIPO_PARITY_EN
        check("cyc_q_par", 32'(bus.q_par), 32'(^m_q));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input logic [3:0] exp_ack, input logic [7:0] exp_q,
                            input string name);
        for (int n = 0; n < 12; n++) begin
            tick();
            if (bus.ack != 4'b0000) break;
        end
        check({name, "_ack"}, 32'(bus.ack), 32'(exp_ack));
        check({name, "_q"},   32'(bus.q),   32'(exp_q));
    endtask

    initial begin
        bus.req     = '0;
        bus.wr_data = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Load once, then reset in the middle of the next GRANT.
        bus.req = 4'b0001;
        bus.wr_data[0*8 +: 8] = 8'h5A;
        wait_ack(4'b0001, 8'h5A, "pre_rst");
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b0001;
        bus.wr_data[0*8 +: 8] = 8'h77;
        tick();
        check("rst_pre_grant", 32'(bus.grant), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_q",     32'(bus.q),     32'h0);
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_busy",  32'(bus.busy),  32'h0);
        bus.req = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // All four requesting: service order 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) bus.wr_data[i*8 +: 8] = 8'(8'h10 + i);
        bus.req = 4'b1111;
        wait_ack(4'b0001, 8'h10, "rr0");
        wait_ack(4'b0010, 8'h11, "rr1");
        wait_ack(4'b0100, 8'h12, "rr2");
        wait_ack(4'b1000, 8'h13, "rr3");
        wait_ack(4'b0001, 8'h10, "rr4");
        bus.req = 4'b0000;
        tick();
        check("model_ptr_after_rr", 32'(m_ptr), 32'd1);

        // Single requester 2 with latency checks.
        bus.req = 4'b0100;
        bus.wr_data[2*8 +: 8] = 8'hA5;
        tick();
        check("single_grant", 32'(bus.grant), 32'h4);
        tick();
        check("single_q",     32'(bus.q),     32'hA5);
        check("single_ack",   32'(bus.ack),   32'h4);
        check("single_owner", 32'(bus.owner), 32'd2);
        bus.req = 4'b0000;
        tick();
        check("single_busy",  32'(bus.busy),  32'h0);

        // Pointer now at 3: requester 3 before 0.
        bus.wr_data[3*8 +: 8] = 8'hC3;
        bus.wr_data[0*8 +: 8] = 8'h3C;
        bus.req = 4'b1001;
        wait_ack(4'b1000, 8'hC3, "wrap3");
        bus.req[3] = 1'b0;
        wait_ack(4'b0001, 8'h3C, "wrap0");
        bus.req = 4'b0000;
        tick();

        // Abort: requester 1 withdraws during GRANT.
        bus.req = 4'b0010;
        bus.wr_data[1*8 +: 8] = 8'h99;
        tick();
        check("abort_grant", 32'(bus.grant), 32'h2);
        bus.req = 4'b0000;
        tick();
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_ack",  32'(bus.ack),  32'h0);
        check("abort_q",    32'(bus.q),    32'h3C);
        tick();
        check("abort_ack2", 32'(bus.ack),  32'h0);

`ifdef PIPO_PARITY_EN
        bus.req = 4'b0100;
        bus.wr_data[2*8 +: 8] = 8'h07;
        wait_ack(4'b0100, 8'h07, "par07");
        check("par07_bit", 32'(bus.q_par), 32'h1);
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b0100;
        bus.wr_data[2*8 +: 8] = 8'h03;
        wait_ack(4'b0100, 8'h03, "par03");
        check("par03_bit", 32'(bus.q_par), 32'h0);
        bus.req = 4'b0000;
        tick();
`endif

        // Random requesters: hold until ack, occasional withdrawals and data changes.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req[i]) begin
                    if (bus.ack[i] || $urandom_range(15) == 0) bus.req[i] = 1'b0;
                    else if ($urandom_range(7) == 0) bus.wr_data[i*8 +: 8] = 8'($urandom);
                end else if ($urandom_range(3) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.wr_data[i*8 +: 8] = 8'($urandom);
                end
            end
            tick();
        end
        bus.req = 4'b0000;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
